// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator.
package led_pkg;

  // Width of the BREATHE duty and pwm counters.
  localparam int unsigned PWM_W = 8;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_SHIFT   = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } bounce_dir_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Step prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last one.
// The count only advances while en is high, so a pause resumes where it left off.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 15625000
) (
  input  logic clk_125,
  input  logic rst,
  input  logic en,
  output logic step
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Step on the last enabled count; wrap on the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    step  = en && (cnt_q == CNT_MAX);
    if (step) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register; reset discards any partially elapsed step.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT, SHIFT, BOUNCE and (optionally) BREATHE patterns,
// advanced once per prescaler step. Define LED_BREATHE_EN to build the BREATHE
// duty/pwm logic; without it mode 11 is treated as COUNT.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned LED_W    = 4,
  parameter int unsigned TICK_DIV = 15625000,
  parameter int unsigned BR_STEP  = 16
) (
  input  logic             clk_125,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             tick
);

  // Reject unusable parameter sets at elaboration.
  if (LED_W == 0 || TICK_DIV == 0 || BR_STEP == 0 || BR_STEP > 255) begin : g_param_check
    $error("led_pattern_gen: parameter out of range");
  end

  logic             step;
  mode_e            mode_in, mode_q, mode_d;
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] bnc_pat;
  bounce_dir_e      bdir_q, bdir_d, bnc_dir;
  logic             tick_q;

`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] BR_INC   = PWM_W'(BR_STEP);
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

  logic [PWM_W-1:0] duty_q, duty_d, br_duty;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [PWM_W:0]   duty_sum;
  breathe_dir_e     brdir_q, brdir_d, br_dir;
`endif

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_125(clk_125),
    .rst    (rst),
    .en     (en),
    .step   (step)
  );

  // Effective mode: without the BREATHE build, mode 11 aliases COUNT.
  always_comb begin
`ifdef LED_BREATHE_EN
    mode_in = mode_e'(mode);
`else
    mode_in = (mode_e'(mode) == MODE_BREATHE) ? MODE_COUNT : mode_e'(mode);
`endif
  end

  // BOUNCE FSM next state: turn around when the lit bit reaches an end.
  always_comb begin
    bnc_pat = pattern_q;
    bnc_dir = bdir_q;
    if (LED_W > 1) begin
      unique case (bdir_q)
        DIR_LEFT: begin
          if (pattern_q[LED_W-1]) begin
            bnc_dir = DIR_RIGHT;
            bnc_pat = pattern_q >> 1;
          end else begin
            bnc_pat = pattern_q << 1;
          end
        end
        DIR_RIGHT: begin
          if (pattern_q[0]) begin
            bnc_dir = DIR_LEFT;
            bnc_pat = pattern_q << 1;
          end else begin
            bnc_pat = pattern_q >> 1;
          end
        end
      endcase
    end
  end

`ifdef LED_BREATHE_EN
  // BREATHE FSM next state: saturating ramp, reversing at either end.
  always_comb begin
    duty_sum = {1'b0, duty_q} + {1'b0, BR_INC};
    br_duty  = duty_q;
    br_dir   = brdir_q;
    unique case (brdir_q)
      DIR_UP: begin
        if (duty_sum >= {1'b0, DUTY_MAX}) begin
          br_duty = DUTY_MAX;
          br_dir  = DIR_DOWN;
        end else begin
          br_duty = duty_sum[PWM_W-1:0];
        end
      end
      DIR_DOWN: begin
        if (duty_q <= BR_INC) begin
          br_duty = '0;
          br_dir  = DIR_UP;
        end else begin
          br_duty = duty_q - BR_INC;
        end
      end
    endcase
  end
`endif

  // Step logic: a mode change loads the new mode's start state, else advance.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    bdir_d    = bdir_q;
    led_d     = led_q;
`ifdef LED_BREATHE_EN
    duty_d    = duty_q;
    brdir_d   = brdir_q;
    pwm_d     = en ? pwm_q + 1'b1 : pwm_q;
`endif
    if (step) begin
      mode_d = mode_in;
      if (mode_in != mode_q) begin
        unique case (mode_in)
          MODE_COUNT:  pattern_d = '0;
          MODE_SHIFT:  pattern_d = LED_W'(1);
          MODE_BOUNCE: begin
            pattern_d = LED_W'(1);
            bdir_d    = DIR_LEFT;
          end
`ifdef LED_BREATHE_EN
          MODE_BREATHE: begin
            duty_d  = '0;
            brdir_d = DIR_UP;
          end
`endif
          default: ;
        endcase
      end else begin
        unique case (mode_q)
          MODE_COUNT:  pattern_d = pattern_q + 1'b1;
          MODE_SHIFT:  pattern_d = (pattern_q << 1) | (pattern_q >> (LED_W - 1));
          MODE_BOUNCE: begin
            pattern_d = bnc_pat;
            bdir_d    = bnc_dir;
          end
`ifdef LED_BREATHE_EN
          MODE_BREATHE: begin
            duty_d  = br_duty;
            brdir_d = br_dir;
          end
`endif
          default: ;
        endcase
      end
      led_d = pattern_d;
    end
`ifdef LED_BREATHE_EN
    // In BREATHE every enabled cycle refreshes led from the pwm compare.
    if (en && mode_d == MODE_BREATHE) begin
      led_d = {LED_W{pwm_q < duty_d}};
    end
`endif
  end

  // State registers; reset takes priority over enable and step.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      mode_q    <= MODE_COUNT;
      pattern_q <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
      bdir_q    <= DIR_LEFT;
`ifdef LED_BREATHE_EN
      duty_q    <= '0;
      brdir_q   <= DIR_UP;
      pwm_q     <= '0;
`endif
    end else begin
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      tick_q    <= step;
      bdir_q    <= bdir_d;
`ifdef LED_BREATHE_EN
      duty_q    <= duty_d;
      brdir_q   <= brdir_d;
      pwm_q     <= pwm_d;
`endif
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: the stimulus process runs a reference
// model and queues expected (cycle, led) pairs for each step; the monitor pops
// them whenever the DUT raises tick, plus queued snapshot checks of led/tick.
module tb_led_pattern_gen;

  localparam int unsigned LED_W    = 4;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BR_STEP  = 64;
  localparam int unsigned BNC_PER  = 2 * (LED_W - 1);

  logic             clk_125 = 1'b0;
  logic             rst     = 1'b1;
  logic             en      = 1'b0;
  logic [1:0]       mode    = 2'b00;
  logic [LED_W-1:0] led;
  logic             tick;

  led_pattern_gen #(
    .LED_W   (LED_W),
    .TICK_DIV(TICK_DIV),
    .BR_STEP (BR_STEP)
  ) dut (
    .clk_125(clk_125),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .led    (led),
    .tick   (tick)
  );

  initial forever #4 clk_125 = ~clk_125;

  typedef struct {
    int unsigned      cyc;
    logic [LED_W-1:0] led;
  } exp_t;

  typedef struct {
    int unsigned      cyc;
    logic [LED_W-1:0] led;
    logic             tick;
    int               code;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snap_q[$];
  exp_t  mon_e;
  snap_t mon_s;

  int unsigned cyc = 0;
  always @(posedge clk_125) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  // Reference model state: enabled cycles since reset, steps since mode load.
  int unsigned      en_cnt = 0;
  int unsigned      k      = 0;
  int               m_mode = 0;
  logic [LED_W-1:0] cur_led = '0;
  logic             m_tick = 1'b0;

  // Duty sequence for BR_STEP=64: ramps up, saturates at 255, ramps down to 0.
  int unsigned duty_tbl [8] = '{0, 64, 128, 192, 255, 191, 127, 63};

  function automatic int eff_mode(input logic [1:0] m);
`ifdef LED_BREATHE_EN
    return int'(m);
`else
    return (m == 2'b11) ? 0 : int'(m);
`endif
  endfunction

  function automatic logic [LED_W-1:0] pattern_of(input int md, input int unsigned kk,
                                                  input int unsigned pwm);
    int unsigned pos;
    int unsigned b;
    logic [LED_W-1:0] one;
    one = 1;
    case (md)
      0: return LED_W'(kk % (1 << LED_W));
      1: return one << (kk % LED_W);
      2: begin
        pos = kk % BNC_PER;
        b   = (pos < LED_W) ? pos : BNC_PER - pos;
        return one << b;
      end
      default: return (pwm < duty_tbl[kk % 8]) ? '1 : '0;
    endcase
  endfunction

  function automatic string snap_name(input int c);
    case (c)
      0:       return "reset_state";
      1:       return "en_freeze";
      default: return "mid_reset";
    endcase
  endfunction

  // Drive one cycle of inputs and advance the model to the following edge.
  task automatic drive(input logic r, input logic e, input logic [1:0] m);
    int unsigned pwm;
    bit stp;
    @(negedge clk_125);
    rst    = r;
    en     = e;
    mode   = m;
    m_tick = 1'b0;
    if (r) begin
      en_cnt  = 0;
      k       = 0;
      m_mode  = 0;
      cur_led = '0;
    end else if (e) begin
      stp = (en_cnt % TICK_DIV) == TICK_DIV - 1;
      pwm = en_cnt % 256;
      en_cnt++;
      if (stp) begin
        if (eff_mode(m) != m_mode) begin
          m_mode = eff_mode(m);
          k      = 0;
        end else begin
          k++;
        end
        m_tick = 1'b1;
      end
      if (stp || m_mode == 3) cur_led = pattern_of(m_mode, k, pwm);
      if (stp) exp_q.push_back('{cyc: cyc + 1, led: cur_led});
    end
  endtask

  task automatic snap(input int code);
    snap_q.push_back('{cyc: cyc + 1, led: cur_led, tick: m_tick, code: code});
  endtask

  // Monitor: snapshot checks, then tick-driven scoreboard pops.
  always @(negedge clk_125) begin
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      mon_s = snap_q.pop_front();
      total++;
      if (led !== mon_s.led) begin
        bad++;
        $display("FAIL %s led: got %b want %b (cycle %0d)", snap_name(mon_s.code), led,
                 mon_s.led, cyc);
      end
      total++;
      if (tick !== mon_s.tick) begin
        bad++;
        $display("FAIL %s tick: got %b want %b (cycle %0d)", snap_name(mon_s.code), tick,
                 mon_s.tick, cyc);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missed_tick: got no tick want tick with led %b at cycle %0d", mon_e.led,
               mon_e.cyc);
    end
    if (tick === 1'b1) begin
      total++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        bad++;
        $display("FAIL unexpected_tick: got tick with led %b at cycle %0d want no tick", led, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (led !== mon_e.led) begin
          bad++;
          $display("FAIL step_led: got %b want %b (cycle %0d)", led, mon_e.led, cyc);
        end
      end
    end
    if (done) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL pending_ticks: got %0d unserved want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    logic [1:0] rm;
    rm = 2'b00;
    // Reset, then COUNT through a full wrap.
    drive(1'b1, 1'b1, 2'b00);
    drive(1'b1, 1'b1, 2'b00);
    snap(0);
    repeat (17 * TICK_DIV) drive(1'b0, 1'b1, 2'b00);
    // SHIFT, then BOUNCE.
    repeat (5 * TICK_DIV) drive(1'b0, 1'b1, 2'b01);
    repeat (8 * TICK_DIV) drive(1'b0, 1'b1, 2'b10);
    // Pause with the prescaler part-way through a step.
    for (int i = 0; i < 2 * TICK_DIV && (en_cnt % TICK_DIV) != 2; i++) drive(1'b0, 1'b1, 2'b10);
    repeat (10) begin
      drive(1'b0, 1'b0, 2'b10);
      snap(1);
    end
    repeat (3 * TICK_DIV) drive(1'b0, 1'b1, 2'b10);
    // Reset while BOUNCE shows 0100 on its way back right.
    for (int i = 0; i < 200 && !(m_mode == 2 && (k % BNC_PER) == 4); i++) begin
      drive(1'b0, 1'b1, 2'b10);
    end
    drive(1'b1, 1'b1, 2'b10);
    snap(2);
    repeat (6 * TICK_DIV) drive(1'b0, 1'b1, 2'b10);
    // Mode 11 (BREATHE, or COUNT when not built in).
    repeat (20 * TICK_DIV) drive(1'b0, 1'b1, 2'b11);
    // Random traffic: occasional mode changes, pauses and resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) rm = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, rm);
    end
    repeat (3) drive(1'b0, 1'b0, rm);
    done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no end of run want summary before time limit");
    $fatal(1, "timeout");
  end

endmodule
